// File: rtl/videoaxis_pkg.sv
// Shared types and helpers for the AXI4-Stream video to DRAM frame-buffer writer.
package videoaxis_pkg;

   localparam int DATA_W = 36;
   localparam int CMD_W  = 40;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_SOF,
      ST_CAPTURE,
      ST_FLUSH
   } state_t;

   // DRAM word: all byte lanes enabled, pixel bytes reordered, pad byte set.
   function automatic logic [DATA_W-1:0] pack_pixel(input logic [23:0] px);
      return {4'hf, px[23:16], px[7:0], px[15:8], 8'hff};
   endfunction

endpackage

// File: rtl/videoaxis2dram_fb_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid whenever empty is low.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // NOTE: pointers are sequential state, so they use non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/videoaxis2dram_fb.sv
// Captures AXI4-Stream RGB frames into a ring of DRAM frame buffers using line-bounded bursts.
module videoaxis2dram_fb
   import videoaxis_pkg::*;
#(
   parameter int unsigned WIDTH            = 1600,
   parameter int unsigned HEIGHT           = 900,
   parameter int unsigned BURST_LEN        = 64,
   parameter int unsigned FIFO_DEPTH       = 256,
   parameter int unsigned CMD_DEPTH        = 8,
   parameter int unsigned NUM_FRAMES       = 2,
   parameter logic [31:0] MEM_STARTADDRESS = 32'h0,
   parameter logic [31:0] LINE_STRIDE      = 32'(WIDTH * 4),
   parameter logic [31:0] FRAME_STRIDE     = 32'h0060_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [23:0]       s_axis_tdata,
   input  logic              s_axis_tuser,
   input  logic              s_axis_tlast,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] data_in,
   output logic              data_we,
   input  logic              data_ready,
   output logic [CMD_W-1:0]  ctrl_in,
   output logic              ctrl_we,
   input  logic              ctrl_ready,
   input  logic              capture_sig,
   output logic              capture_busy,
   output logic              frame_done,
   output logic              frame_error,
   output logic [1:0]        frame_index
);

   localparam logic [11:0] X_LAST    = 12'(WIDTH - 1);
   localparam logic [11:0] Y_LAST    = 12'(HEIGHT - 1);
   localparam logic [7:0]  BLEN_LAST = 8'(BURST_LEN - 1);
   localparam logic [1:0]  IDX_LAST  = 2'(NUM_FRAMES - 1);
   localparam int          PW        = $clog2(CMD_DEPTH) + 1;

   state_t          state, state_nx;
   logic            armed, abort, orphan;
   logic [11:0]     x, y, x_start, burst_start;
   logic [7:0]      bcnt;
   logic [PW-1:0]   pending;

   logic            accept, take, sof_abort, in_range, push_px, closing, drained;
   logic            cmd_push, pend_inc, pend_dec;
   logic [7:0]      cmd_len;
   logic [31:0]     burst_addr;
   logic [DATA_W:0] data_head;
   logic [CMD_W-1:0] cmd_head;
   logic            data_empty, data_full, cmd_empty, cmd_full;

   // A beat that might close a burst cannot be predicted (tlast), so any full command slot stalls input.
   always_comb begin
      s_axis_tready = 1'b0;
      case (state)
         ST_IDLE, ST_WAIT_SOF: s_axis_tready = armed;
         ST_CAPTURE:           s_axis_tready = !data_full && !cmd_full;
         default:              s_axis_tready = 1'b0;
      endcase
   end

   assign accept    = s_axis_tvalid && s_axis_tready;
   assign take      = accept && ((state == ST_CAPTURE && !s_axis_tuser) ||
                                 (state == ST_WAIT_SOF && s_axis_tuser));
   assign sof_abort = accept && (state == ST_CAPTURE) && s_axis_tuser;
   assign in_range  = (x <= X_LAST) && (y <= Y_LAST);
   assign push_px   = take && in_range;
   assign closing   = (bcnt == BLEN_LAST) || (x == X_LAST) || s_axis_tlast;
   assign burst_start = (bcnt == 8'd0) ? x : x_start;
   assign burst_addr  = MEM_STARTADDRESS + 32'(frame_index) * FRAME_STRIDE
                      + 32'(y) * LINE_STRIDE + {18'd0, burst_start, 2'b00};
   assign cmd_push  = (push_px && closing) || (sof_abort && bcnt != 8'd0);
   assign cmd_len   = push_px ? bcnt + 8'd1 : bcnt;
   assign drained   = data_empty && cmd_empty && (pending == '0);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:     if (capture_sig) state_nx = ST_WAIT_SOF;
         ST_WAIT_SOF: begin
            if (take)              state_nx = (s_axis_tlast && y == Y_LAST) ? ST_FLUSH : ST_CAPTURE;
            else if (!capture_sig) state_nx = ST_IDLE;
         end
         ST_CAPTURE:  if (sof_abort || (take && s_axis_tlast && y == Y_LAST)) state_nx = ST_FLUSH;
         ST_FLUSH:    if (drained) state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   assign capture_busy = (state == ST_CAPTURE) || (state == ST_FLUSH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed       <= 1'b0;
         abort       <= 1'b0;
         orphan      <= 1'b0;
         x           <= '0;
         y           <= '0;
         x_start     <= '0;
         bcnt        <= '0;
         pending     <= '0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         frame_index <= '0;
      end else begin
         armed       <= 1'b1;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         if (take) begin
            if (bcnt == 8'd0) x_start <= x;
            if (s_axis_tlast) begin
               x    <= '0;
               y    <= y + 12'd1;
               bcnt <= '0;
               if (x < X_LAST) frame_error <= 1'b1;
            end else begin
               if (x != 12'hfff) x <= x + 12'd1;
               if (in_range) bcnt <= closing ? 8'd0 : bcnt + 8'd1;
            end
         end else if (state != ST_CAPTURE) begin
            x    <= '0;
            y    <= '0;
            bcnt <= '0;
         end
         // An aborted frame closes its open burst; that command may issue once its words have drained.
         if (sof_abort) begin
            frame_error <= 1'b1;
            abort       <= 1'b1;
            orphan      <= (bcnt != 8'd0);
         end
         if (state == ST_FLUSH && drained) begin
            frame_done <= !abort;
            abort      <= 1'b0;
         end
         if (frame_done) frame_index <= (frame_index == IDX_LAST) ? 2'd0 : frame_index + 2'd1;
         if (ctrl_we && ctrl_ready && pending == '0) orphan <= 1'b0;
         pending <= pending + PW'(pend_inc) - PW'(pend_dec);
      end
   end

   sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_data_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_px),
      .push_data ({closing, pack_pixel(s_axis_tdata)}),
      .pop       (data_we),
      .head      (data_head),
      .empty     (data_empty),
      .full      (data_full)
   );

   sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cmd_push),
      .push_data ({cmd_len, burst_addr}),
      .pop       (ctrl_we && ctrl_ready),
      .head      (cmd_head),
      .empty     (cmd_empty),
      .full      (cmd_full)
   );

   assign data_we  = !data_empty && data_ready;
   assign data_in  = data_empty ? '0 : data_head[DATA_W-1:0];
   assign pend_inc = data_we && data_head[DATA_W];
   assign ctrl_we  = !cmd_empty && ((pending != '0) || (orphan && data_empty));
   assign ctrl_in  = cmd_empty ? '0 : cmd_head;
   assign pend_dec = ctrl_we && ctrl_ready && (pending != '0);

endmodule

// File: tb/tb_videoaxis2dram_fb.sv
// Directed bench: expected burst commands per frame are hand-computed tables; data words come from a pixel model.
module tb_videoaxis2dram_fb;

   localparam int          W    = 10;
   localparam int          H    = 4;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [31:0] LS   = 32'd40;
   localparam logic [31:0] FS   = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] s_axis_tdata = '0;
   logic        s_axis_tuser = 1'b0, s_axis_tlast = 1'b0, s_axis_tvalid = 1'b0;
   logic        data_ready = 1'b1, ctrl_ready = 1'b1, capture_sig = 1'b0;
   logic        s_axis_tready, data_we, ctrl_we, capture_busy, frame_done, frame_error;
   logic [35:0] data_in;
   logic [39:0] ctrl_in;
   logic [1:0]  frame_index;

   always #5 clk = ~clk;

   videoaxis2dram_fb #(
      .WIDTH(W), .HEIGHT(H), .BURST_LEN(4), .FIFO_DEPTH(16), .CMD_DEPTH(8), .NUM_FRAMES(2),
      .MEM_STARTADDRESS(BASE), .LINE_STRIDE(LS), .FRAME_STRIDE(FS)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .data_in(data_in), .data_we(data_we), .data_ready(data_ready),
      .ctrl_in(ctrl_in), .ctrl_we(ctrl_we), .ctrl_ready(ctrl_ready),
      .capture_sig(capture_sig), .capture_busy(capture_busy),
      .frame_done(frame_done), .frame_error(frame_error), .frame_index(frame_index)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [35:0] pack(input logic [23:0] d);
      return {4'hf, d[23:16], d[7:0], d[15:8], 8'hff};
   endfunction

   typedef struct packed {logic [7:0] len; logic [31:0] addr;} cmd_t;
   typedef struct {logic [7:0] len; logic [31:0] off;} exp_cmd_t;

   cmd_t        cmd_log[$];
   logic [35:0] data_log[$];
   logic [35:0] exp_data[$];
   exp_cmd_t    tbl[$];

   int          words_seen = 0, cmd_words = 0, accepted = 0, done_cnt = 0, err_cnt = 0;
   logic [1:0]  done_idx = '0;
   logic        stall_prev = 1'b0;
   logic [39:0] ctrl_prev = '0;

   // Output monitor, sampled mid-cycle; inputs only change just after the rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("ctrl_hold_we", ctrl_we, 1'b1);
            check("ctrl_hold_in", ctrl_in, ctrl_prev);
         end
         if (ctrl_we && ctrl_ready) begin
            cmd_words += int'(ctrl_in[39:32]);
            check("cmd_after_data", 64'(words_seen >= cmd_words), 64'd1);
            cmd_log.push_back(cmd_t'(ctrl_in));
         end
         stall_prev = ctrl_we && !ctrl_ready;
         ctrl_prev  = ctrl_in;
         if (data_we) begin
            data_log.push_back(data_in);
            words_seen++;
         end
         if (s_axis_tvalid && s_axis_tready) accepted++;
         if (frame_done) begin
            done_cnt++;
            done_idx = frame_index;
         end
         if (frame_error) err_cnt++;
      end
   end

   task automatic beat(input logic [23:0] d, input logic u, input logic l);
      int n;
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_axis_tready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!s_axis_tready) check("beat_accept", s_axis_tready, 1'b1);
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_line(input int f, input int y, input int n, input bit sof, input bit eol);
      logic [23:0] d;
      for (int x = 0; x < n; x++) begin
         d = {8'(f), 8'(y), 8'(x)};
         beat(d, sof && x == 0, eol && x == n - 1);
         if (x < W && y < H) exp_data.push_back(pack(d));
      end
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (capture_busy && n < 3000);
      check("frame_end", capture_busy, 1'b0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic add_cmd(input logic [7:0] len, input logic [31:0] off);
      exp_cmd_t e;
      e.len = len;
      e.off = off;
      tbl.push_back(e);
   endtask

   task automatic add_full_frame();
      add_cmd(4, 0);   add_cmd(4, 16);  add_cmd(2, 32);
      add_cmd(4, 40);  add_cmd(4, 56);  add_cmd(2, 72);
      add_cmd(4, 80);  add_cmd(4, 96);  add_cmd(2, 112);
      add_cmd(4, 120); add_cmd(4, 136); add_cmd(2, 152);
   endtask

   task automatic compare(input string tag, input logic [31:0] base);
      check({tag, "_ncmd"}, cmd_log.size(), tbl.size());
      for (int i = 0; i < tbl.size() && i < cmd_log.size(); i++) begin
         check($sformatf("%s_len%0d", tag, i), cmd_log[i].len, tbl[i].len);
         check($sformatf("%s_addr%0d", tag, i), cmd_log[i].addr, base + tbl[i].off);
      end
      check({tag, "_nword"}, data_log.size(), exp_data.size());
      for (int i = 0; i < exp_data.size() && i < data_log.size(); i++)
         check($sformatf("%s_word%0d", tag, i), data_log[i], exp_data[i]);
      cmd_log.delete();
      data_log.delete();
      exp_data.delete();
      tbl.delete();
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tready"}, s_axis_tready, 1'b0);
      check({tag, "_data_we"}, data_we, 1'b0);
      check({tag, "_data_in"}, data_in, 36'h0);
      check({tag, "_ctrl_we"}, ctrl_we, 1'b0);
      check({tag, "_ctrl_in"}, ctrl_in, 40'h0);
      check({tag, "_busy"}, capture_busy, 1'b0);
      check({tag, "_done"}, frame_done, 1'b0);
      check({tag, "_error"}, frame_error, 1'b0);
      check({tag, "_index"}, frame_index, 2'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      capture_sig = 1'b1;
      // Beats before the start of frame are discarded.
      beat(24'h00_0707, 1'b0, 1'b0);
      beat(24'h00_0808, 1'b0, 1'b1);

      // Frame 0: clean frame into buffer 0.
      for (int y = 0; y < H; y++) send_line(0, y, W, y == 0, 1'b1);
      wait_end();
      add_full_frame();
      check("f0_done_cnt", done_cnt, 1);
      check("f0_done_idx", done_idx, 2'd0);
      check("f0_err_cnt", err_cnt, 0);
      check("f0_index_after", frame_index, 2'd1);
      compare("f0", BASE);

      // Frame 1: short line 1, long line 2, command port stalling.
      fork
         begin
            send_line(1, 0, 10, 1'b1, 1'b1);
            send_line(1, 1, 6, 1'b0, 1'b1);
            send_line(1, 2, 12, 1'b0, 1'b1);
            send_line(1, 3, 10, 1'b0, 1'b1);
            wait_end();
         end
         begin
            for (int i = 0; i < 60; i++) begin
               @(posedge clk);
               #1;
               ctrl_ready = (i % 3) != 0;
            end
            ctrl_ready = 1'b1;
         end
      join
      add_cmd(4, 0);   add_cmd(4, 16);  add_cmd(2, 32);
      add_cmd(4, 40);  add_cmd(2, 56);
      add_cmd(4, 80);  add_cmd(4, 96);  add_cmd(2, 112);
      add_cmd(4, 120); add_cmd(4, 136); add_cmd(2, 152);
      check("f1_done_cnt", done_cnt, 1);
      check("f1_done_idx", done_idx, 2'd1);
      check("f1_err_cnt", err_cnt, 1);
      check("f1_index_after", frame_index, 2'd0);
      compare("f1", BASE + FS);

      // Frame 2: DRAM data port stalled; input must stop once the data FIFO holds 16 words.
      data_ready = 1'b0;
      accepted   = 0;
      fork
         begin
            for (int y = 0; y < H; y++) send_line(2, y, W, y == 0, 1'b1);
            wait_end();
         end
         begin
            repeat (300) @(negedge clk);
            check("bp_accepted", accepted, 16);
            check("bp_tready", s_axis_tready, 1'b0);
            @(posedge clk);
            #1;
            data_ready = 1'b1;
         end
      join
      add_full_frame();
      check("f2_done_cnt", done_cnt, 1);
      check("f2_done_idx", done_idx, 2'd0);
      check("f2_index_after", frame_index, 2'd1);
      compare("f2", BASE);

      // Frame 3: premature SOF in line 1 after six pixels.
      send_line(3, 0, 10, 1'b1, 1'b1);
      send_line(3, 1, 6, 1'b0, 1'b0);
      beat(24'h03_0106, 1'b1, 1'b0);
      wait_end();
      add_cmd(4, 0); add_cmd(4, 16); add_cmd(2, 32);
      add_cmd(4, 40); add_cmd(2, 56);
      check("f3_done_cnt", done_cnt, 0);
      check("f3_err_cnt", err_cnt, 1);
      check("f3_index_kept", frame_index, 2'd1);
      compare("f3", BASE + FS);

      // Asynchronous reset with words parked in the data FIFO.
      data_ready = 1'b0;
      send_line(4, 0, 3, 1'b1, 1'b0);
      check("pre_rst_busy", capture_busy, 1'b1);
      @(negedge clk);
      #2;
      rst_n      = 1'b0;
      data_ready = 1'b1;
      #1;
      check_all_zero("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      data_log.delete();
      repeat (10) @(negedge clk);
      check("post_rst_words", data_log.size(), 0);
      check("post_rst_busy", capture_busy, 1'b0);
      check("post_rst_index", frame_index, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
